// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, stall/flush control with selectable
// priority, and saturating stall/flush event counters.
module pipe_stage_hs #(
  parameter int unsigned       DATA_W           = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL        = '0,
  parameter bit                FLUSH_OVER_STALL = 1'b0,
  parameter int unsigned       CNT_W            = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic stall_eff, flush_eff;
  logic in_fire, out_fire;

  always_comb begin
    if (FLUSH_OVER_STALL) begin
      flush_eff = flush_i;
      stall_eff = stall_i & ~flush_i;
    end else begin
      stall_eff = stall_i;
      flush_eff = flush_i & ~stall_i;
    end
  end

  // Ready depends only on local state, never on out_ready_i.
  assign in_ready_o = ~skid_v_q & ~stall_eff & rst_i;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = main_v_q & out_ready_i & ~stall_eff;

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (flush_eff) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d_d = FLUSH_VAL;
    end else if (!stall_eff) begin
      if (!main_v_q) begin
        if (in_fire) begin
          main_v_d = 1'b1;
          main_d_d = in_data_i;
        end
      end else if (out_fire) begin
        if (skid_v_q) begin
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end else if (in_fire) begin
          main_d_d = in_data_i;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data_i;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_eff && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_eff && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_d_q    <= FLUSH_VAL;
      skid_d_q    <= FLUSH_VAL;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_d_q    <= main_d_d;
      skid_d_q    <= skid_d_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid_o = main_v_q;
  assign out_data_o  = main_d_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: three instances sharing stimulus (stall-priority,
// flush-priority with a non-zero bubble, and a 3-bit counter variant).
module tb_pipe_stage_hs;

  localparam logic [63:0] FV1 = 64'hDEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, stall, flush;
  logic [63:0] in_data;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [63:0] od0, od1, od2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [2:0]  sc2, fc2;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(64), .FLUSH_OVER_STALL(1'b0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data),
    .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0), .stall_i(stall),
    .flush_i(flush), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  pipe_stage_hs #(.DATA_W(64), .FLUSH_VAL(FV1), .FLUSH_OVER_STALL(1'b1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data),
    .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .stall_i(stall),
    .flush_i(flush), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  pipe_stage_hs #(.DATA_W(64), .FLUSH_OVER_STALL(1'b0), .CNT_W(3)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy2), .in_data_i(in_data),
    .out_valid_o(ov2), .out_ready_i(out_ready), .out_data_o(od2), .stall_i(stall),
    .flush_i(flush), .stall_cnt_o(sc2), .flush_cnt_o(fc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_data = 64'hA; out_ready = 1'b1;
    stall = 1'b0; flush = 1'b0;

    // Reset
    step(); step();
    chk("rst_ov", 64'(ov0), 64'd0);
    chk("rst_od", od0, 64'd0);
    chk("rst_rdy", 64'(rdy0), 64'd0);
    chk("rst_od_fv", od1, FV1);
    rst = 1'b1;
    #1;
    chk("rel_rdy", 64'(rdy0), 64'd1);
    step();
    in_valid = 1'b0;
    chk("first_ov", 64'(ov0), 64'd1);
    chk("first_od", od0, 64'hA);
    chk("first_sc", 64'(sc0), 64'd0);
    chk("first_fc", 64'(fc0), 64'd0);
    step();
    chk("drain_ov", 64'(ov0), 64'd0);
    chk("drain_keep_od", od0, 64'hA);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      #1;
      chk("stream_rdy", 64'(rdy0), 64'd1);
      step();
      chk("stream_ov", 64'(ov0), 64'd1);
      chk("stream_od", od0, 64'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_ov", 64'(ov0), 64'd0);

    // Backpressure into skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'd1;
    step();
    in_data = 64'd2;
    #1;
    chk("bp_rdy_skid", 64'(rdy0), 64'd1);
    step();
    in_data = 64'd3;
    #1;
    chk("bp_rdy_full", 64'(rdy0), 64'd0);
    step();
    chk("bp_hold_od", od0, 64'd1);
    chk("bp_hold_rdy", 64'(rdy0), 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_od2", od0, 64'd2);
    chk("bp_rdy_again", 64'(rdy0), 64'd1);
    step();
    chk("bp_od3", od0, 64'd3);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 64'(ov0), 64'd0);

    // Stall vs flush
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h55;
    step();
    out_ready = 1'b1;
    in_data = 64'h66; stall = 1'b1; flush = 1'b1;
    #1;
    chk("sf_rdy0", 64'(rdy0), 64'd0);
    chk("sf_rdy1", 64'(rdy1), 64'd1);
    step();
    chk("sf0_ov", 64'(ov0), 64'd1);
    chk("sf0_od", od0, 64'h55);
    chk("sf0_sc", 64'(sc0), 64'd1);
    chk("sf0_fc", 64'(fc0), 64'd0);
    chk("sf1_ov", 64'(ov1), 64'd0);
    chk("sf1_od", od1, FV1);
    chk("sf1_fc", 64'(fc1), 64'd1);
    chk("sf1_sc", 64'(sc1), 64'd0);
    stall = 1'b0;
    step();
    chk("fl0_ov", 64'(ov0), 64'd0);
    chk("fl0_od", od0, 64'd0);
    chk("fl0_fc", 64'(fc0), 64'd1);
    chk("fl0_sc", 64'(sc0), 64'd1);
    chk("fl1_fc", 64'(fc1), 64'd2);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl0_dropped", 64'(ov0), 64'd0);
    chk("fl1_dropped", 64'(ov1), 64'd0);

    // Reset mid-transfer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77;
    step();
    in_valid = 1'b0; rst = 1'b0;
    step();
    chk("midrst_ov", 64'(ov0), 64'd0);
    chk("midrst_od", od0, 64'd0);
    rst = 1'b1;
    chk("midrst_sc", 64'(sc0), 64'd0);
    chk("midrst_fc", 64'(fc0), 64'd0);

    // Counter saturation
    stall = 1'b1;
    repeat (10) step();
    chk("sat_sc2", 64'(sc2), 64'd7);
    chk("nosat_sc0", 64'(sc0), 64'd10);
    stall = 1'b0;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline stage register. Successor to the fixed 32-bit instruction/PC stage latch.
- Carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake.
- Has a 2-entry skid buffer, so full throughput holds with a registered ready.
- Supports stall and flush with selectable priority, a configurable bubble payload, and saturating stall/flush event counters for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (e.g. instruction + PC concatenated).
- FLUSH_VAL, {DATA_W{1'b0}}, payload driven on out_data_o when the stage holds a bubble (flush/reset); 0 = NOP encoding.
- FLUSH_OVER_STALL, 0, 0: stall_i has priority over flush_i; 1: flush_i has priority over stall_i.
- CNT_W, 16, width of the event counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-low (0 = reset).
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  stage holds a valid payload.
- out_ready_i  in  1  downstream accepts the payload.
- out_data_o  out  DATA_W  payload to the next stage.
- stall_i  in  1  freeze the stage.
- flush_i  in  1  discard all held payloads.
- stall_cnt_o  out  CNT_W  cycles with an effective stall, saturating.
- flush_cnt_o  out  CNT_W  cycles with an effective flush, saturating.

Behaviour:
- Storage:
  - main register: main_v, main_d; drives out_valid_o = main_v and out_data_o = main_d.
  - skid register: skid_v, skid_d.
- Effective controls:
  - FLUSH_OVER_STALL=0: stall_eff = stall_i; flush_eff = flush_i & ~stall_i.
  - FLUSH_OVER_STALL=1: flush_eff = flush_i; stall_eff = stall_i & ~flush_i.
- Handshake:
  - in_ready_o = ~skid_v & ~stall_eff & rst_i.
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = main_v & out_ready_i & ~stall_eff.
  - in_ready_o must not depend on out_ready_i (no combinational ready path through the stage).
- Reset (rst_i=0 at a clock edge):
  - main_v=0, skid_v=0, main_d=FLUSH_VAL, skid_d=FLUSH_VAL, both counters=0.
  - in_ready_o reads 0 while rst_i=0.
  - A reset mid-transfer discards both entries with no output.
- Flush (flush_eff=1):
  - main_v=0, skid_v=0, main_d=FLUSH_VAL.
  - Input that cycle is dropped, even if in_fire was asserted (upstream is being flushed too).
  - flush_cnt_o increments.
- Stall (stall_eff=1):
  - All payload state holds; no in_fire, no out_fire.
  - out_valid_o and out_data_o stay stable.
  - stall_cnt_o increments.
- Normal cycle, priority order:
  - main empty: if in_fire, main <= in.
  - main full, out_fire, skid empty: main <= in if in_fire, else main_v <= 0.
  - main full, out_fire, skid full: main <= skid; skid_v <= 0 (in_ready_o was 0).
  - main full, no out_fire: if in_fire, skid <= in (skid was empty).
- Ordering and throughput:
  - Payloads exit in arrival order; none duplicated or lost outside flush/reset.
  - Latency 1 cycle in_fire -> out_valid_o; sustained throughput 1/cycle with out_ready_i=1.
- Data and counters:
  - main_d keeps its last value when main_v=0 after a normal drain (not forced to FLUSH_VAL).
  - Counters saturate at 2^CNT_W-1; no wrap.
- Invariant: skid_v=1 implies main_v=1.

Test Plan:
- Reset: DATA_W=64, rst_i=0 for 2 cycles with in_valid_i=1 -> out_valid_o=0, out_data_o=0, in_ready_o=0; after release in_ready_o=1 and the first payload 0xA appears 1 cycle after acceptance.
- Streaming: 8 back-to-back payloads 1..8 with out_ready_i=1 -> outputs 1..8 on consecutive cycles, in_ready_o constantly 1.
- Backpressure and skid: out_ready_i=0 while sending 1,2,3 -> main=1, skid=2, in_ready_o=0, payload 3 held upstream; out_ready_i=1 -> order 1,2,3, no loss.
- Stall vs flush, FLUSH_OVER_STALL=0:
  - Stage holding 0x55 with stall_i=1 and flush_i=1 -> 0x55 held, stall_cnt_o +1, flush_cnt_o unchanged.
  - Then stall_i=0, flush_i=1 -> out_valid_o=0, out_data_o=FLUSH_VAL, incoming payload dropped.
- Stall vs flush, FLUSH_OVER_STALL=1: same stimulus -> flush wins on the first cycle; both entries cleared, flush_cnt_o=1, stall_cnt_o=0.
- Counter saturation: CNT_W=3, stall_i=1 for 10 cycles -> stall_cnt_o stops at 7.
